// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store bus controller: issues SRAM-like req/addr_ok/data_ok transactions,
// stalls M until completion, and registers the M->W op/address/raw read word. Optional ADDR_EXC_EN.
module mem_access_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validM,
    input  logic [7:0]    alucontrolM,
    input  logic [AW-1:0] dataadrM,
    input  logic [DW-1:0] writedataM,
    input  logic          stall_ext,
    input  logic          flushW,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [3:0]    data_wstrb,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic [DW-1:0] data_rdata,
    input  logic          data_data_ok,
    output logic          mem_stall,
    output logic [7:0]    alucontrolW,
    output logic [AW-1:0] dataadrW,
    output logic [DW-1:0] readdataW
`ifdef ADDR_EXC_EN
    ,
    output logic          adelM,
    output logic          adesM
`endif
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state_q;
    logic [DW-1:0] rbuf_q;
    logic [7:0]    alucontrolW_q;
    logic [AW-1:0] dataadrW_q;
    logic [DW-1:0] readdataW_q;

    logic          is_load, is_store, is_half, is_word;
    logic          misaligned;
    logic          mem_op;
    logic          wait_ok;
    logic          advance;
    logic [7:0]    alucontrolW_d;
    logic [DW-1:0] readdataW_d;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        data_size = 2'd2;
        unique case (alucontrolM)
            EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; data_size = 2'd2; end
            EXE_LH_OP,
            EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; data_size = 2'd1; end
            EXE_LB_OP,
            EXE_LBU_OP: begin is_load  = 1'b1;                 data_size = 2'd0; end
            EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; data_size = 2'd2; end
            EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; data_size = 2'd1; end
            EXE_SB_OP:  begin is_store = 1'b1;                 data_size = 2'd0; end
            default:    ;
        endcase
    end

`ifdef ADDR_EXC_EN
    assign misaligned = (is_word & (dataadrM[1:0] != 2'b00)) | (is_half & dataadrM[0]);
    assign adelM      = validM & is_load  & misaligned;
    assign adesM      = validM & is_store & misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign mem_op    = validM & (is_load | is_store) & ~misaligned;
    assign data_wr   = is_store;
    assign data_addr = dataadrM;

    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = writedataM;
        if (is_store) begin
            unique case (data_size)
                2'd0: begin
                    data_wstrb = 4'b0001 << dataadrM[1:0];
                    data_wdata = {4{writedataM[7:0]}};
                end
                2'd1: begin
                    data_wstrb = dataadrM[1] ? 4'b1100 : 4'b0011;
                    data_wdata = {2{writedataM[15:0]}};
                end
                default: data_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        unique case (state_q)
            S_IDLE:  data_req = mem_op;
            S_REQ:   data_req = 1'b1;
            default: data_req = 1'b0;
        endcase
    end

    // A response arriving outside WAIT is stale and deliberately ignored.
    assign wait_ok   = (state_q == S_WAIT) & data_data_ok;
    assign mem_stall = mem_op & ~wait_ok & ~(state_q == S_DONE);
    assign advance   = ~mem_stall & ~stall_ext;

    always_comb begin
        alucontrolW_d = (validM & ~misaligned) ? alucontrolM : 8'h00;
        readdataW_d   = '0;
        if (mem_op & is_load)
            readdataW_d = wait_ok ? data_rdata : rbuf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rbuf_q        <= '0;
            alucontrolW_q <= '0;
            dataadrW_q    <= '0;
            readdataW_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mem_op & data_addr_ok) state_q <= S_WAIT;
                    else if (mem_op)           state_q <= S_REQ;
                end
                S_REQ: begin
                    if (data_addr_ok) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        rbuf_q  <= data_rdata;
                        state_q <= stall_ext ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!stall_ext) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (advance) begin
                if (flushW) begin
                    alucontrolW_q <= '0;
                    dataadrW_q    <= '0;
                    readdataW_q   <= '0;
                end else begin
                    alucontrolW_q <= alucontrolW_d;
                    dataadrW_q    <= dataadrM;
                    readdataW_q   <= readdataW_d;
                end
            end
        end
    end

    assign alucontrolW = alucontrolW_q;
    assign dataadrW    = dataadrW_q;
    assign readdataW   = readdataW_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table of single transactions plus hand-written
// multi-cycle sequences; W-stage results are checked through an expected-value queue.
module tb_mem_access_ctrl;

    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] SB  = 8'b1110_1000;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;
    localparam logic [7:0] ADDOP = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM;
    logic [7:0]  alucontrolM;
    logic [31:0] dataadrM;
    logic [31:0] writedataM;
    logic        stall_ext;
    logic        flushW;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        mem_stall;
    logic [7:0]  alucontrolW;
    logic [31:0] dataadrW;
    logic [31:0] readdataW;
`ifdef ADDR_EXC_EN
    logic        adelM;
    logic        adesM;
`endif

    mem_access_ctrl #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .validM(validM), .alucontrolM(alucontrolM),
        .dataadrM(dataadrM), .writedataM(writedataM), .stall_ext(stall_ext), .flushW(flushW),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok), .mem_stall(mem_stall),
        .alucontrolW(alucontrolW), .dataadrW(dataadrW), .readdataW(readdataW)
`ifdef ADDR_EXC_EN
        , .adelM(adelM), .adesM(adesM)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int req_cnt = 0;

    always @(posedge clk) if (data_req) req_cnt <= req_cnt + 1;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        is_mem;
        logic        is_load;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] rd;
    } wexp_t;

    wexp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_w(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rd);
        wexp_t e;
        e.op = op; e.addr = addr; e.rd = rd;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk_w(input string nm);
        wexp_t e;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_opW"}, {24'd0, alucontrolW}, {24'd0, e.op});
            chk({nm, "_adrW"}, dataadrW, e.addr);
            chk({nm, "_rdW"}, readdataW, e.rd);
        end
    endtask

    task automatic idle_inputs();
        validM = 1'b0; alucontrolM = 8'h00; dataadrM = 32'h0; writedataM = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        stall_ext = 1'b0; flushW = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] rd;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        validM = 1'b1; alucontrolM = v.op; dataadrM = v.addr; writedataM = v.wd;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        chk({nm, "_req"}, {31'd0, data_req}, {31'd0, v.is_mem});
        chk({nm, "_wr"}, {31'd0, data_wr}, {31'd0, v.wr});
        if (v.is_mem) chk({nm, "_size"}, {30'd0, data_size}, {30'd0, v.size});
        chk({nm, "_addr"}, data_addr, v.addr);
        chk({nm, "_wstrb"}, {28'd0, data_wstrb}, {28'd0, v.wstrb});
        if (v.wr) chk({nm, "_wdata"}, data_wdata, v.wdata);
        chk({nm, "_stall0"}, {31'd0, mem_stall}, {31'd0, v.is_mem});
        data_addr_ok = 1'b1;
        @(negedge clk);
        rd = $urandom;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
        push_w(v.op, v.addr, v.is_load ? rd : 32'h0);
        #1;
        chk({nm, "_stall1"}, {31'd0, mem_stall}, 32'd0);
        chk({nm, "_req1"}, {31'd0, data_req}, 32'd0);
        @(negedge clk);
        validM = 1'b0; data_data_ok = 1'b0;
        pop_chk_w(nm);
    endtask

    vec_t vecs[11];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int r0;

        vecs[0]  = '{LW,    32'h100, 32'h0,        1, 1, 0, 2'd2, 4'b0000, 32'h0};
        vecs[1]  = '{SB,    32'h203, 32'h0000_00A5, 1, 0, 1, 2'd0, 4'b1000, 32'hA5A5_A5A5};
        vecs[2]  = '{SH,    32'h202, 32'h0000_1234, 1, 0, 1, 2'd1, 4'b1100, 32'h1234_1234};
        vecs[3]  = '{SH,    32'h200, 32'h0000_BEEF, 1, 0, 1, 2'd1, 4'b0011, 32'hBEEF_BEEF};
        vecs[4]  = '{SB,    32'h200, 32'h0000_003C, 1, 0, 1, 2'd0, 4'b0001, 32'h3C3C_3C3C};
        vecs[5]  = '{SB,    32'h201, 32'hFFFF_FF77, 1, 0, 1, 2'd0, 4'b0010, 32'h7777_7777};
        vecs[6]  = '{SW,    32'h404, 32'hCAFE_F00D, 1, 0, 1, 2'd2, 4'b1111, 32'hCAFE_F00D};
        vecs[7]  = '{LH,    32'h106, 32'h0,        1, 1, 0, 2'd1, 4'b0000, 32'h0};
        vecs[8]  = '{LBU,   32'h107, 32'h0,        1, 1, 0, 2'd0, 4'b0000, 32'h0};
        vecs[9]  = '{LHU,   32'h10A, 32'h0,        1, 1, 0, 2'd1, 4'b0000, 32'h0};
        vecs[10] = '{ADDOP, 32'h55,  32'h0,        0, 0, 0, 2'd0, 4'b0000, 32'h0};

        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_opW", {24'd0, alucontrolW}, 32'd0);
        chk("rst_adrW", dataadrW, 32'd0);
        chk("rst_rdW", readdataW, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // LB with stale data_ok held in the issue cycle: must not complete early
        @(negedge clk);
        validM = 1'b1; alucontrolM = LB; dataadrM = 32'h105; data_data_ok = 1'b1; data_rdata = 32'h1;
        #1;
        chk("stale_ok_stall", {31'd0, mem_stall}, 32'd1);
        data_data_ok = 1'b0; data_addr_ok = 1'b1;
        @(negedge clk);
        rd = 32'h0102_0304;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
        push_w(LB, 32'h105, rd);
        @(negedge clk);
        validM = 1'b0; data_data_ok = 1'b0;
        pop_chk_w("lb");

        // addr_ok withheld three cycles
        @(negedge clk);
        validM = 1'b1; alucontrolM = SW; dataadrM = 32'h808; writedataM = 32'h1357_9BDF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("hold%0d_req", i), {31'd0, data_req}, 32'd1);
            chk($sformatf("hold%0d_addr", i), data_addr, 32'h808);
            chk($sformatf("hold%0d_wstrb", i), {28'd0, data_wstrb}, 32'hF);
            chk($sformatf("hold%0d_stall", i), {31'd0, mem_stall}, 32'd1);
            if (i == 3) data_addr_ok = 1'b1;
            @(negedge clk);
        end
        data_addr_ok = 1'b0;
        #1;
        chk("hold_wait_stall", {31'd0, mem_stall}, 32'd1);
        chk("hold_wait_req", {31'd0, data_req}, 32'd0);
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000;
        push_w(SW, 32'h808, 32'h0);
        #1;
        chk("hold_ok_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        validM = 1'b0; data_data_ok = 1'b0;
        pop_chk_w("hold");

        // flushW on the completing cycle clears W
        @(negedge clk);
        validM = 1'b1; alucontrolM = LW; dataadrM = 32'h500; data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA; flushW = 1'b1;
        @(negedge clk);
        validM = 1'b0; data_data_ok = 1'b0; flushW = 1'b0;
        chk("flush_opW", {24'd0, alucontrolW}, 32'd0);
        chk("flush_adrW", dataadrW, 32'd0);
        chk("flush_rdW", readdataW, 32'd0);

        // data_ok while stall_ext held: DONE, single request, W updates on release
        @(negedge clk);
        r0 = req_cnt;
        validM = 1'b1; alucontrolM = LW; dataadrM = 32'h300; data_addr_ok = 1'b1;
        @(negedge clk);
        rd = 32'hC0DE_F00D;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd; stall_ext = 1'b1;
        #1;
        chk("done_ok_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("done_req", {31'd0, data_req}, 32'd0);
        chk("done_stall", {31'd0, mem_stall}, 32'd0);
        chk("done_rdW_hold", readdataW, 32'd0);
        @(negedge clk);
        stall_ext = 1'b0;
        push_w(LW, 32'h300, rd);
        #1;
        chk("done_rel_req", {31'd0, data_req}, 32'd0);
        @(negedge clk);
        validM = 1'b0;
        pop_chk_w("done");
        chk("done_req_count", req_cnt - r0, 32'd1);

        // reset while in WAIT, then a late data_ok
        @(negedge clk);
        validM = 1'b1; alucontrolM = LW; dataadrM = 32'h600; data_addr_ok = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rstw_req", {31'd0, data_req}, 32'd0);
        chk("rstw_opW", {24'd0, alucontrolW}, 32'd0);
        chk("rstw_adrW", dataadrW, 32'd0);
        chk("rstw_rdW", readdataW, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
        #1;
        chk("late_ok_req", {31'd0, data_req}, 32'd0);
        chk("late_ok_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("late_ok_rdW", readdataW, 32'd0);
        chk("late_ok_opW", {24'd0, alucontrolW}, 32'd0);

`ifdef ADDR_EXC_EN
        @(negedge clk);
        validM = 1'b1; alucontrolM = LW; dataadrM = 32'h102;
        #1;
        chk("exc_lw_adel", {31'd0, adelM}, 32'd1);
        chk("exc_lw_ades", {31'd0, adesM}, 32'd0);
        chk("exc_lw_req", {31'd0, data_req}, 32'd0);
        chk("exc_lw_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        chk("exc_lw_opW", {24'd0, alucontrolW}, 32'd0);
        alucontrolM = SH; dataadrM = 32'h101;
        #1;
        chk("exc_sh_ades", {31'd0, adesM}, 32'd1);
        chk("exc_sh_adel", {31'd0, adelM}, 32'd0);
        chk("exc_sh_req", {31'd0, data_req}, 32'd0);
        @(negedge clk);
        validM = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
